// File: rtl/br_history_checkpoint_buffer_pkg.sv
// Shared types for the branch-history checkpoint buffer.
// Entry/tag/history types plus the history-shift helper.
package br_history_checkpoint_buffer_pkg;

   localparam int BR_CKPT_ENTRY_NUM = 16;
   localparam int BR_CKPT_TAG_WIDTH = $clog2(BR_CKPT_ENTRY_NUM);
   localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 10;

   typedef logic [BR_CKPT_TAG_WIDTH-1:0] BrCkptTagPath;
   typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0]
      BranchGlobalHistoryPath;

   typedef struct packed {
      logic                   valid;
      BranchGlobalHistoryPath history;
   } BrCkptEntry;

   // History after the branch: shift in the actual direction.
   function automatic BranchGlobalHistoryPath nextHistory(
      input BranchGlobalHistoryPath h,
      input logic                   taken
   );
      return {h[BRANCH_GLOBAL_HISTORY_BIT_WIDTH-2:0], taken};
   endfunction

endpackage

// File: rtl/br_history_checkpoint_buffer_oldest_select.sv
// Picks the oldest mispredicting resolve lane relative to head.
// In: head, laneValid/laneTag/laneMispred. Out: hit, lane, tag.
module br_ckpt_oldest_select #(
   parameter int LANES = 2,
   parameter int TW    = 4,
   localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [TW-1:0]       head,
   input  logic [LANES-1:0]    laneValid,
   input  logic [LANES*TW-1:0] laneTag,
   input  logic [LANES-1:0]    laneMispred,
   output logic                hit,
   output logic [LW-1:0]       lane,
   output logic [TW-1:0]       tag
);

   logic [TW-1:0] age;
   logic [TW-1:0] bestAge;

   always_comb begin
      hit     = 1'b0;
      lane    = '0;
      tag     = '0;
      age     = '0;
      bestAge = '0;
      for (int i = 0; i < LANES; i++) begin
         // Age wraps naturally because the depth is a power of two.
         age = laneTag[i*TW +: TW] - head;
         if (laneValid[i] && laneMispred[i]) begin
            if (!hit || age < bestAge) begin
               hit     = 1'b1;
               lane    = LW'(i);
               tag     = laneTag[i*TW +: TW];
               bestAge = age;
            end
         end
      end
   end

endmodule

// File: rtl/br_history_checkpoint_buffer.sv
// Circular checkpoint buffer of pre-prediction global history.
// Ports: alloc*, resolve*, commitNum in; allocReady/allocTag,
// recoverBrHistory/recoveredBrHistory, count, stat* out.
// Optional stats counters: define BR_CKPT_STATS_EN.
module br_history_checkpoint_buffer
   import br_history_checkpoint_buffer_pkg::*;
#(
   parameter int ENTRY_NUM       = BR_CKPT_ENTRY_NUM,
   parameter int FETCH_WIDTH     = 2,
   parameter int INT_ISSUE_WIDTH = 2,
   parameter int COMMIT_WIDTH    = 2,
   parameter int GH_WIDTH        = BRANCH_GLOBAL_HISTORY_BIT_WIDTH,
   localparam int TW = $clog2(ENTRY_NUM),
   localparam int CW = $clog2(ENTRY_NUM + 1),
   localparam int NW = $clog2(COMMIT_WIDTH + 1),
   localparam int LW = (INT_ISSUE_WIDTH > 1) ?
                       $clog2(INT_ISSUE_WIDTH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [FETCH_WIDTH-1:0]       allocValid,
   input  logic [FETCH_WIDTH*GH_WIDTH-1:0] allocHistory,
   output logic                         allocReady,
   output logic [FETCH_WIDTH*TW-1:0]    allocTag,
   input  logic [INT_ISSUE_WIDTH-1:0]   resolveValid,
   input  logic [INT_ISSUE_WIDTH*TW-1:0] resolveTag,
   input  logic [INT_ISSUE_WIDTH-1:0]   resolveMispred,
   input  logic [INT_ISSUE_WIDTH-1:0]   resolveTaken,
   input  logic [NW-1:0]                commitNum,
   output logic                         recoverBrHistory,
   output logic [GH_WIDTH-1:0]          recoveredBrHistory,
   output logic [CW-1:0]                count,
   output logic [31:0]                  statMispred,
   output logic [31:0]                  statAllocStall
);

   BrCkptEntry entries [ENTRY_NUM];
   BrCkptEntry entNext [ENTRY_NUM];

   logic [TW-1:0] head, tail, headNext, tailNext;
   logic [CW-1:0] countNext, allocNum, commitEff, keep;
   logic [CW-1:0] freeNum;
   logic [TW-1:0] entAge, selAge, selTag;
   logic [LW-1:0] selLane;
   logic          hit;
   logic [INT_ISSUE_WIDTH-1:0] laneValid;

   always_comb begin
      for (int i = 0; i < INT_ISSUE_WIDTH; i++)
         laneValid[i] = resolveValid[i] &&
            entries[resolveTag[i*TW +: TW]].valid;
   end

   br_ckpt_oldest_select #(
      .LANES (INT_ISSUE_WIDTH),
      .TW    (TW)
   ) uSel (
      .head        (head),
      .laneValid   (laneValid),
      .laneTag     (resolveTag),
      .laneMispred (resolveMispred),
      .hit         (hit),
      .lane        (selLane),
      .tag         (selTag)
   );

   always_comb begin
      freeNum    = CW'(ENTRY_NUM) - count;
      allocReady = freeNum >= CW'(FETCH_WIDTH);
      for (int i = 0; i < FETCH_WIDTH; i++)
         allocTag[i*TW +: TW] = tail + TW'(i);
      allocNum = '0;
      for (int i = 0; i < FETCH_WIDTH; i++)
         allocNum = allocNum + CW'(allocValid[i]);
      // Over-commit is a caller error; never free past the tail.
      commitEff = (CW'(commitNum) > count) ? count : CW'(commitNum);
   end

   always_comb begin
      entNext   = entries;
      entAge    = '0;
      selAge    = selTag - head;
      keep      = CW'(selAge) + CW'(1);
      headNext  = head + TW'(commitEff);
      tailNext  = tail;
      countNext = count - commitEff;
      for (int j = 0; j < ENTRY_NUM; j++) begin
         entAge = TW'(j) - head;
         if (CW'(entAge) < commitEff)
            entNext[j].valid = 1'b0;
         if (hit && entAge > selAge)
            entNext[j].valid = 1'b0;
      end
      if (hit) begin
         // Survivors are head..selTag; commit may free some of them.
         tailNext  = selTag + TW'(1);
         countNext = keep - ((commitEff > keep) ? keep : commitEff);
      end else if (allocReady) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (allocValid[i]) begin
               entNext[tail + TW'(i)].valid   = 1'b1;
               entNext[tail + TW'(i)].history =
                  allocHistory[i*GH_WIDTH +: GH_WIDTH];
            end
         end
         tailNext  = tail + TW'(allocNum);
         countNext = count + allocNum - commitEff;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < ENTRY_NUM; j++)
            entries[j] <= '0;
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         recoverBrHistory   <= 1'b0;
         recoveredBrHistory <= '0;
      end else begin
         entries          <= entNext;
         head             <= headNext;
         tail             <= tailNext;
         count            <= countNext;
         recoverBrHistory <= hit;
         if (hit)
            recoveredBrHistory <= nextHistory(
               entries[selTag].history, resolveTaken[selLane]);
      end
   end

`ifdef BR_CKPT_STATS_EN
   logic [31:0] mispredCnt, stallCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredCnt <= '0;
         stallCnt   <= '0;
      end else begin
         if (hit && mispredCnt != '1)
            mispredCnt <= mispredCnt + 32'd1;
         if ((|allocValid) && !allocReady && stallCnt != '1)
            stallCnt <= stallCnt + 32'd1;
      end
   end

   assign statMispred    = mispredCnt;
   assign statAllocStall = stallCnt;
`else
   assign statMispred    = '0;
   assign statAllocStall = '0;
`endif

endmodule
